keystream_scheduler: RTL and testbench
======================================

// Module: keystream_scheduler
// PURPOSE
//  Sequences the hash generator on behalf of the encryption block: it issues hash-byte requests,
//  prefetches keystream bytes into a small FIFO, and hands them out one per consumer request.
//  Tracks key-load progress, and flushes stale keystream on key writes or hash reset.
//  Sits between data_router/reader (key and reset pulses), hash_generator and encryption_block.
// PARAMETERS
//  KEY_BYTES     16   key bytes required before keystream generation may start
//  FIFO_DEPTH    4    prefetched keystream bytes held (power of 2, >=2)
//  HASH_TIMEOUT  255  max cycles in WAIT for hash_byte_pulse before abort
// PORTS
//  clk                 in   1  system clock, all state on rising edge
//  nrst                in   1  asynchronous active-low reset
//  key_byte_pulse      in   1  one-cycle pulse: key byte written to key storage
//  reset_hash_pulse    in   1  one-cycle pulse: hash generator restarted
//  consumer_req_pulse  in   1  one-cycle pulse from encryption block: needs one keystream byte
//  hash_ready          in   1  hash generator idle, may accept a request
//  hash_byte           in   8  keystream byte from hash generator
//  hash_byte_pulse     in   1  hash_byte valid this cycle
//  hash_req_pulse      out  1  one-cycle request to hash generator
//  ks_byte             out  8  keystream byte to encryption block
//  ks_byte_pulse       out  1  ks_byte valid this cycle
//  key_loaded          out  1  KEY_BYTES key bytes received
//  fifo_count          out  $clog2(FIFO_DEPTH)+1  bytes currently buffered
//  timeout_err         out  1  sticky: hash response timed out
//  overrun_err         out  1  sticky: consumer request dropped
// BEHAVIOUR
//  Reset: all outputs 0. FSM=IDLE, FIFO empty, key count 0, pending=0, discard=0.
//  Key count: +1 per key_byte_pulse, saturates at KEY_BYTES. key_loaded=(count==KEY_BYTES);
//   only nrst clears it.
//  Flush = key_byte_pulse OR reset_hash_pulse. It empties the FIFO the same cycle; a same-cycle
//   push is also dropped. It does not clear pending.
//  FSM states:
//   IDLE:  if key_loaded && fifo_count<FIFO_DEPTH && hash_ready && !flush -> ISSUE.
//   ISSUE: hash_req_pulse=1 for exactly this cycle. Timer=0. -> WAIT.
//   WAIT:  hash_byte_pulse -> push hash_byte, then IDLE. Flush -> DRAIN.
//          Timer reaches HASH_TIMEOUT -> set timeout_err, then IDLE.
//   DRAIN: hash_byte_pulse -> discard it, then IDLE. Timeout -> set timeout_err, then IDLE.
//          A further flush keeps DRAIN.
//   Flush while in ISSUE -> DRAIN (the request is already out).
//  hash_byte_pulse seen in IDLE/ISSUE is ignored.
//  At most one hash request is outstanding. Minimum spacing between hash_req_pulse is 3 cycles.
//  Consumer side (ks_* outputs registered):
//   - consumer_req_pulse with FIFO non-empty (pre-flush): next cycle ks_byte_pulse=1,
//     ks_byte=head, and the byte is popped.
//   - Request with FIFO empty, or a same-cycle flush: set pending.
//   - pending && FIFO non-empty: serve next cycle, then clear pending. The earliest case is the
//     cycle after the push (bypass not required).
//   - Request while pending=1 and not serviceable: drop it and set overrun_err.
//   - Pop and push in the same cycle are both honoured; fifo_count is unchanged.
//   - A push into a full FIFO cannot occur (IDLE gating). An assertion checks this.
//  ks_byte holds its last value when ks_byte_pulse=0.
//  FIFO uses a circular buffer. Pointers wrap modulo FIFO_DEPTH. The count is separate, so full
//   and empty are unambiguous.
//  Errors are sticky until nrst.
//  nrst asserted mid-operation: immediate return to reset state. Any in-flight hash response
//   after release is ignored (FSM in IDLE).
// TESTING
//  1. Reset, send 15 key pulses -> key_loaded=0, no hash_req_pulse.
//     16th pulse -> key_loaded=1; first hash_req_pulse within 2 cycles.
//  2. hash_ready=1, generator answers 2 cycles after each request with 0xA0,0xA1,...
//     -> fifo_count rises to 4, then requests stop.
//     consumer_req_pulse -> next cycle ks_byte=0xA0 with pulse; refill request follows.
//  3. FIFO empty, consumer_req_pulse -> no ks pulse (pending).
//     Hash byte 0x5C arrives -> ks_byte=0x5C pulse within 2 cycles; pending cleared.
//     Then two requests on an empty FIFO -> overrun_err=1.
//  4. reset_hash_pulse during WAIT, late response 0x77 -> 0x77 never appears on ks_byte.
//     FIFO count=0, and the next request is issued after DRAIN.
//  5. Generator never answers -> after 255 WAIT cycles timeout_err=1, FSM re-issues from IDLE.
//  6. nrst low mid-WAIT with 3 bytes buffered -> all outputs 0, fifo_count=0.
//     key_loaded=0 until 16 new key pulses.

Source files
------------

// File: rtl/keystream_scheduler.sv
// Keystream scheduler: requests hash bytes one at a time, buffers them in a small
// circular FIFO and serves one byte per encryption-block request.
module keystream_scheduler #(
  parameter int KEY_BYTES    = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int HASH_TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        key_byte_pulse,
  input  logic                        reset_hash_pulse,
  input  logic                        consumer_req_pulse,
  input  logic                        hash_ready,
  input  logic [7:0]                  hash_byte,
  input  logic                        hash_byte_pulse,
  output logic                        hash_req_pulse,
  output logic [7:0]                  ks_byte,
  output logic                        ks_byte_pulse,
  output logic                        key_loaded,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        timeout_err,
  output logic                        overrun_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int KW = $clog2(KEY_BYTES + 1);
  localparam int TW = $clog2(HASH_TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [KW-1:0] KEY_LAST = KW'(KEY_BYTES);
  localparam logic [TW-1:0] TMO_LAST = TW'(HASH_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_timer;
  logic [KW-1:0]   r_key_cnt;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_pending;
  logic [7:0]      r_ks_byte;
  logic            r_ks_pulse;
  logic            r_timeout_err;
  logic            r_overrun_err;

  logic            w_flush;
  logic            w_loaded;
  logic            w_tmo;
  logic            w_tmo_set;
  logic            w_push;
  logic            w_hash_req;
  logic            w_want;
  logic            w_can_pop;
  logic            w_pop;
  logic            w_overrun;

  assign w_flush   = key_byte_pulse | reset_hash_pulse;
  assign w_loaded  = (r_key_cnt == KEY_LAST);
  assign w_tmo     = (r_timer == TMO_LAST);
  // A flush empties the FIFO this cycle, so it must not also hand out the old head.
  assign w_want    = consumer_req_pulse | r_pending;
  assign w_can_pop = (r_count != '0) && !w_flush;
  assign w_pop     = w_want && w_can_pop;
  assign w_overrun = consumer_req_pulse && r_pending && !w_pop;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hash_req  = 1'b0;
    w_push      = 1'b0;
    w_tmo_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_loaded && (r_count < DEPTH_C) && hash_ready && !w_flush)
          w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_hash_req  = 1'b1;
        w_state_nxt = w_flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (hash_byte_pulse) begin
          w_push      = !w_flush;
          w_state_nxt = S_IDLE;
        end else if (w_tmo) begin
          w_tmo_set   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_flush) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The response to a request made before the flush is stale: swallow it.
        if (hash_byte_pulse) begin
          w_state_nxt = S_IDLE;
        end else if (w_tmo) begin
          w_tmo_set   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                                        r_timer <= '0;
    else if (r_state == S_ISSUE)                      r_timer <= '0;
    else if ((r_state == S_WAIT) || (r_state == S_DRAIN)) r_timer <= r_timer + TW'(1);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                                          r_key_cnt <= '0;
    else if (key_byte_pulse && (r_key_cnt != KEY_LAST)) r_key_cnt <= r_key_cnt + KW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= hash_byte;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_pending     <= 1'b0;
      r_ks_byte     <= '0;
      r_ks_pulse    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_ks_pulse <= w_pop;
      if (w_pop) r_ks_byte <= r_mem[r_rd_ptr];
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
      // A fresh request arriving while an older one is served stays queued as pending.
      if (w_pop)                   r_pending <= r_pending & consumer_req_pulse;
      else if (consumer_req_pulse) r_pending <= 1'b1;
      if (w_tmo_set) r_timeout_err <= 1'b1;
      if (w_overrun) r_overrun_err <= 1'b1;
    end
  end

  a_no_full_push: assert property (@(posedge clk) disable iff (!nrst)
    !(w_push && (r_count == DEPTH_C)));

  assign hash_req_pulse = w_hash_req;
  assign ks_byte        = r_ks_byte;
  assign ks_byte_pulse  = r_ks_pulse;
  assign key_loaded     = w_loaded;
  assign fifo_count     = r_count;
  assign timeout_err    = r_timeout_err;
  assign overrun_err    = r_overrun_err;

endmodule

// File: tb/tb_keystream_scheduler.sv
// Bench for keystream_scheduler: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_keystream_scheduler;
  localparam int KB = 16;
  localparam int FD = 4;
  localparam int TO = 255;

  logic       clk = 1'b0;
  logic       nrst;
  logic       key_byte_pulse, reset_hash_pulse, consumer_req_pulse, hash_ready;
  logic [7:0] hash_byte;
  logic       hash_byte_pulse;
  logic       hash_req_pulse;
  logic [7:0] ks_byte;
  logic       ks_byte_pulse, key_loaded, timeout_err, overrun_err;
  logic [2:0] fifo_count;

  int n_chk = 0;
  int n_err = 0;

  keystream_scheduler #(.KEY_BYTES(KB), .FIFO_DEPTH(FD), .HASH_TIMEOUT(TO)) dut (
    .clk(clk), .nrst(nrst),
    .key_byte_pulse(key_byte_pulse), .reset_hash_pulse(reset_hash_pulse),
    .consumer_req_pulse(consumer_req_pulse), .hash_ready(hash_ready),
    .hash_byte(hash_byte), .hash_byte_pulse(hash_byte_pulse),
    .hash_req_pulse(hash_req_pulse), .ks_byte(ks_byte), .ks_byte_pulse(ks_byte_pulse),
    .key_loaded(key_loaded), .fifo_count(fifo_count),
    .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic kp, rp, cr, hr, hp;
    logic [7:0] hb;
    logic e_req, e_ld;
    logic [2:0] e_cnt;
    logic e_ksp;
    logic [7:0] e_ks;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic kp, input logic rp, input logic cr, input logic hp,
                     input logic [7:0] hb);
    key_byte_pulse = kp; reset_hash_pulse = rp; consumer_req_pulse = cr;
    hash_byte_pulse = hp; hash_byte = hb;
    tick();
    key_byte_pulse = 0; reset_hash_pulse = 0; consumer_req_pulse = 0; hash_byte_pulse = 0;
  endtask

  task automatic do_reset();
    key_byte_pulse = 0; reset_hash_pulse = 0; consumer_req_pulse = 0;
    hash_byte_pulse = 0; hash_byte = 0; hash_ready = 0;
    nrst = 0;
    repeat (2) tick();
    nrst = 1;
    tick();
  endtask

  task automatic load_key();
    repeat (KB) cyc(1, 0, 0, 0, 8'h00);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".req"}, hash_req_pulse, 0);
    chk({tag, ".ks"}, ks_byte, 0);
    chk({tag, ".ksp"}, ks_byte_pulse, 0);
    chk({tag, ".ld"}, key_loaded, 0);
    chk({tag, ".cnt"}, fifo_count, 0);
    chk({tag, ".tout"}, timeout_err, 0);
    chk({tag, ".ovr"}, overrun_err, 0);
  endtask

  function automatic void add(input logic kp, cr, hp, input logic [7:0] hb,
                              input logic e_req, e_ld, input logic [2:0] e_cnt,
                              input logic e_ksp, input logic [7:0] e_ks);
    vec_t v;
    v.kp = kp; v.rp = 0; v.cr = cr; v.hr = 1; v.hp = hp; v.hb = hb;
    v.e_req = e_req; v.e_ld = e_ld; v.e_cnt = e_cnt; v.e_ksp = e_ksp; v.e_ks = e_ks;
    tbl.push_back(v);
  endfunction

  // Reference model: FIFO as a queue, hash side as outstanding/stale request bookkeeping.
  logic [7:0] mq[$];
  bit   m_req, m_out, m_stale, m_pend, m_tout, m_ovr, m_ksp;
  logic [7:0] m_ks;
  int   m_age, m_kcnt;

  task automatic model_reset();
    mq.delete();
    m_req = 0; m_out = 0; m_stale = 0; m_pend = 0; m_tout = 0; m_ovr = 0; m_ksp = 0;
    m_ks = 0; m_age = 0; m_kcnt = 0;
  endtask

  task automatic model_step();
    bit flush, push, pop, n_req, n_out, n_stale, n_pend;
    int n_age;
    flush = key_byte_pulse | reset_hash_pulse;
    push = 0; n_req = 0; n_out = m_out; n_stale = m_stale; n_age = m_age;
    if (m_req) begin
      n_out = 1; n_age = 0; n_stale = flush;
    end else if (m_out) begin
      if (hash_byte_pulse) begin
        n_out = 0; push = !m_stale && !flush;
      end else if (m_age == TO - 1) begin
        n_out = 0; m_tout = 1;
      end else begin
        n_age = m_age + 1; n_stale = m_stale | flush;
      end
    end else if (m_kcnt == KB && mq.size() < FD && hash_ready && !flush) begin
      n_req = 1;
    end
    pop = (consumer_req_pulse | m_pend) && mq.size() != 0 && !flush;
    n_pend = m_pend;
    if (pop) begin
      m_ks = mq[0];
      n_pend = m_pend && consumer_req_pulse;
    end else if (consumer_req_pulse) begin
      if (m_pend) m_ovr = 1;
      n_pend = 1;
    end
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(hash_byte);
    end
    if (key_byte_pulse && m_kcnt < KB) m_kcnt++;
    m_ksp = pop; m_pend = n_pend; m_req = n_req; m_out = n_out; m_stale = n_stale;
    m_age = n_age;
  endtask

  task automatic model_cmp(input int i);
    chk($sformatf("rnd%0d.req", i), hash_req_pulse, m_req);
    chk($sformatf("rnd%0d.ks", i), ks_byte, m_ks);
    chk($sformatf("rnd%0d.ksp", i), ks_byte_pulse, m_ksp);
    chk($sformatf("rnd%0d.ld", i), key_loaded, (m_kcnt == KB));
    chk($sformatf("rnd%0d.cnt", i), fifo_count, mq.size());
    chk($sformatf("rnd%0d.tout", i), timeout_err, m_tout);
    chk($sformatf("rnd%0d.ovr", i), overrun_err, m_ovr);
  endtask

  initial begin
    int rdly;
    logic [7:0] rbyte;

    // Vector table: key load, prefetch to full, one consumer pop and the refill.
    for (int k = 0; k < KB - 1; k++) add(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
    add(1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00);
    add(0, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00);
    for (int b = 0; b < 4; b++) begin
      add(0, 0, 0, 8'h00, 0, 1, 3'(b), 0, 8'h00);
      add(0, 0, 1, 8'hA0 + 8'(b), 0, 1, 3'(b + 1), 0, 8'h00);
      if (b < 3) add(0, 0, 0, 8'h00, 1, 1, 3'(b + 1), 0, 8'h00);
      else       add(0, 0, 0, 8'h00, 0, 1, 3'd4, 0, 8'h00);
    end
    add(0, 0, 0, 8'h00, 0, 1, 3'd4, 0, 8'h00);
    add(0, 1, 0, 8'h00, 0, 1, 3'd3, 1, 8'hA0);
    add(0, 0, 0, 8'h00, 1, 1, 3'd3, 0, 8'hA0);
    add(0, 0, 0, 8'h00, 0, 1, 3'd3, 0, 8'hA0);
    add(0, 0, 1, 8'hA4, 0, 1, 3'd4, 0, 8'hA0);
    add(0, 0, 0, 8'h00, 0, 1, 3'd4, 0, 8'hA0);

    do_reset();
    chk_all_zero("rst");
    foreach (tbl[r]) begin
      hash_ready = tbl[r].hr;
      cyc(tbl[r].kp, tbl[r].rp, tbl[r].cr, tbl[r].hp, tbl[r].hb);
      chk($sformatf("t%0d.req", r), hash_req_pulse, tbl[r].e_req);
      chk($sformatf("t%0d.ld", r), key_loaded, tbl[r].e_ld);
      chk($sformatf("t%0d.cnt", r), fifo_count, tbl[r].e_cnt);
      chk($sformatf("t%0d.ksp", r), ks_byte_pulse, tbl[r].e_ksp);
      chk($sformatf("t%0d.ks", r), ks_byte, tbl[r].e_ks);
    end

    // Pending request served by a late byte, then overrun on an empty FIFO.
    do_reset(); load_key();
    chk("pend.ld", key_loaded, 1);
    cyc(0, 0, 1, 0, 8'h00);
    chk("pend.ksp0", ks_byte_pulse, 0);
    hash_ready = 1; cyc(0, 0, 0, 0, 8'h00); hash_ready = 0;
    chk("pend.req", hash_req_pulse, 1);
    cyc(0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 1, 8'h5C);
    chk("pend.cnt1", fifo_count, 1);
    cyc(0, 0, 0, 0, 8'h00);
    chk("pend.ksp1", ks_byte_pulse, 1);
    chk("pend.ks", ks_byte, 8'h5C);
    chk("pend.cnt0", fifo_count, 0);
    cyc(0, 0, 1, 0, 8'h00);
    chk("ovr.first", overrun_err, 0);
    cyc(0, 0, 1, 0, 8'h00);
    chk("ovr.second", overrun_err, 1);
    cyc(0, 0, 0, 0, 8'h00);
    chk("ovr.sticky", overrun_err, 1);

    // Flush during WAIT: the late byte is discarded and a fresh request follows.
    do_reset(); load_key();
    hash_ready = 1; cyc(0, 0, 0, 0, 8'h00); hash_ready = 0;
    chk("drain.req", hash_req_pulse, 1);
    cyc(0, 0, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 8'h00);
    hash_ready = 1;
    cyc(0, 0, 0, 1, 8'h77);
    chk("drain.cnt", fifo_count, 0);
    chk("drain.ksp", ks_byte_pulse, 0);
    chk("drain.noreq", hash_req_pulse, 0);
    cyc(0, 0, 0, 0, 8'h00); hash_ready = 0;
    chk("drain.reissue", hash_req_pulse, 1);
    chk("drain.ks", ks_byte, 0);
    cyc(0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 1, 8'h88);
    cyc(0, 0, 0, 0, 8'h00);
    chk("drain.ksp2", ks_byte_pulse, 1);
    chk("drain.ks2", ks_byte, 8'h88);

    // Generator never answers.
    do_reset(); load_key();
    hash_ready = 1; cyc(0, 0, 0, 0, 8'h00); hash_ready = 0;
    chk("tmo.req", hash_req_pulse, 1);
    cyc(0, 0, 0, 0, 8'h00);
    repeat (TO - 1) cyc(0, 0, 0, 0, 8'h00);
    chk("tmo.early", timeout_err, 0);
    cyc(0, 0, 0, 0, 8'h00);
    chk("tmo.set", timeout_err, 1);
    hash_ready = 1; cyc(0, 0, 0, 0, 8'h00); hash_ready = 0;
    chk("tmo.reissue", hash_req_pulse, 1);

    // Asynchronous reset mid-WAIT with three bytes buffered.
    do_reset(); load_key();
    cyc(0, 0, 1, 0, 8'h00);
    cyc(0, 0, 1, 0, 8'h00);
    hash_ready = 1;
    for (int b = 0; b < 4; b++) begin
      cyc(0, 0, 0, 0, 8'h00);
      chk($sformatf("ar.req%0d", b), hash_req_pulse, 1);
      cyc(0, 0, 0, 0, 8'h00);
      cyc(0, 0, 0, 1, 8'h30 + 8'(b));
    end
    cyc(0, 0, 0, 0, 8'h00); hash_ready = 0;
    cyc(0, 0, 0, 0, 8'h00);
    chk("ar.cnt3", fifo_count, 3);
    chk("ar.ks", ks_byte, 8'h30);
    chk("ar.ovr", overrun_err, 1);
    #2 nrst = 0;
    #1 chk_all_zero("ar");
    tick();
    nrst = 1;
    cyc(0, 0, 0, 1, 8'h99);
    chk("ar.late", fifo_count, 0);
    chk("ar.noreq", hash_req_pulse, 0);
    repeat (KB - 1) cyc(1, 0, 0, 0, 8'h00);
    chk("ar.ld15", key_loaded, 0);
    cyc(1, 0, 0, 0, 8'h00);
    chk("ar.ld16", key_loaded, 1);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    rdly = -1; rbyte = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1200) begin
        #2 nrst = 0;
        #1 model_reset();
        model_cmp(i);
        tick();
        nrst = 1;
      end
      key_byte_pulse     = (i < 400) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 99) == 0);
      reset_hash_pulse   = ($urandom_range(0, 59) == 0);
      consumer_req_pulse = ($urandom_range(0, 3) == 0);
      hash_ready         = ($urandom_range(0, 4) != 0);
      if (rdly == 0) begin
        hash_byte_pulse = 1; hash_byte = rbyte; rdly = -1;
      end else begin
        if (rdly > 0) rdly--;
        hash_byte_pulse = ($urandom_range(0, 49) == 0);
        hash_byte = 8'($urandom);
      end
      model_step();
      tick();
      model_cmp(i);
      if (hash_req_pulse) begin
        if ($urandom_range(0, 29) == 0) rdly = -1;
        else begin
          rdly = $urandom_range(1, 4);
          rbyte = 8'($urandom);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
